// File: rtl/cache_rd_arbiter_pkg.sv
// rtl/cache_rd_arbiter_pkg.sv - shared encodings for the cache refill read arbiter
package cache_rd_arbiter_pkg;

    // Read burst types as carried on x_rd_type / mem_rd_type
    localparam logic [2:0] RD_WORD = 3'b010;
    localparam logic [2:0] RD_LINE = 3'b100;

    // Transaction owner
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Index of the beat that must carry mem_ret_last for a given type.
    // Anything that is not a line refill is treated as a single word.
    function automatic logic [1:0] last_beat_idx(input logic [2:0] rd_type);
        return (rd_type == RD_LINE) ? 2'd3 : 2'd0;
    endfunction

endpackage

// File: rtl/cache_rd_arbiter.sv
// rtl/cache_rd_arbiter.sv - icache/dcache refill read arbiter onto a single bridge port
//
// Arbitrates icache and dcache refill reads onto one memory bridge read port,
// one transaction outstanding at a time. dcache has priority unless icache has
// been starved for STARVE_LIMIT consecutive dcache grants.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   icache_rd_*/dcache_rd_* refill request (req/type/addr in, rdy out)
//   icache_ret_*/dcache_ret_* return beats (valid/last/data out)
//   mem_rd_*               bridge request (req/type/addr out, rdy in)
//   mem_ret_*              bridge return beats (valid/last/data in)
//   protocol_err           sticky return-protocol violation flag
module cache_rd_arbiter
    import cache_rd_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        icache_rd_req,
    input  logic [2:0]  icache_rd_type,
    input  logic [31:0] icache_rd_addr,
    output logic        icache_rd_rdy,
    output logic        icache_ret_valid,
    output logic        icache_ret_last,
    output logic [31:0] icache_ret_data,

    input  logic        dcache_rd_req,
    input  logic [2:0]  dcache_rd_type,
    input  logic [31:0] dcache_rd_addr,
    output logic        dcache_rd_rdy,
    output logic        dcache_ret_valid,
    output logic        dcache_ret_last,
    output logic [31:0] dcache_ret_data,

    output logic        mem_rd_req,
    output logic [2:0]  mem_rd_type,
    output logic [31:0] mem_rd_addr,
    input  logic        mem_rd_rdy,
    input  logic        mem_ret_valid,
    input  logic        mem_ret_last,
    input  logic [31:0] mem_ret_data,

    output logic        protocol_err
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_t        state;
    state_t        state_nxt;

    logic          owner_q;
    logic [2:0]    type_q;
    logic [31:0]   addr_q;
    logic [SW-1:0] starve_cnt;
    logic [1:0]    beat_cnt;
    logic          beat_over;   // expected last index already passed without last
    logic          err_q;

    logic          starved;
    logic          grant_i;
    logic          grant_d;
    logic          accept;
    logic [1:0]    exp_idx;
    logic          resp_beat;
    logic          beat_past;
    logic          err_early;
    logic          err_missing;
    logic          err_stray;
    logic          fwd_i;
    logic          fwd_d;

    // ------------------------------------------------------------------
    // Arbitration and return-protocol checking
    // ------------------------------------------------------------------
    always_comb begin
        starved = (starve_cnt == STARVE_MAX);
        grant_i = (state == ST_IDLE) && icache_rd_req && (!dcache_rd_req || starved);
        grant_d = (state == ST_IDLE) && dcache_rd_req && !grant_i;
        accept  = grant_i || grant_d;

        exp_idx   = last_beat_idx(type_q);
        resp_beat = (state == ST_RESP) && mem_ret_valid;
        beat_past = beat_over || (beat_cnt > exp_idx);

        err_early   = resp_beat && mem_ret_last && ((beat_cnt != exp_idx) || beat_over);
        err_missing = resp_beat && !mem_ret_last && beat_past;
        // Beats outside RESP are dropped and only flagged
        err_stray   = mem_ret_valid && (state != ST_RESP);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)                        state_nxt = ST_REQ;
            ST_REQ:  if (mem_rd_rdy)                    state_nxt = ST_RESP;
            // Follows mem_ret_last even after a protocol violation
            ST_RESP: if (mem_ret_valid && mem_ret_last) state_nxt = ST_IDLE;
            default:                                    state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        icache_rd_rdy = grant_i;
        dcache_rd_rdy = grant_d;

        mem_rd_req  = (state == ST_REQ);
        mem_rd_type = type_q;
        mem_rd_addr = addr_q;

        fwd_i = resp_beat && (owner_q == OWN_I);
        fwd_d = resp_beat && (owner_q == OWN_D);

        icache_ret_valid = fwd_i;
        icache_ret_last  = fwd_i && mem_ret_last;
        icache_ret_data  = fwd_i ? mem_ret_data : 32'h0;

        dcache_ret_valid = fwd_d;
        dcache_ret_last  = fwd_d && mem_ret_last;
        dcache_ret_data  = fwd_d ? mem_ret_data : 32'h0;

        protocol_err = err_q;
    end

    // ------------------------------------------------------------------
    // Request capture and starvation counter
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            owner_q    <= OWN_I;
            type_q     <= 3'b000;
            addr_q     <= 32'h0;
            starve_cnt <= '0;
        end else begin
            if (accept) begin
                owner_q <= grant_d ? OWN_D : OWN_I;
                type_q  <= grant_d ? dcache_rd_type : icache_rd_type;
                addr_q  <= grant_d ? dcache_rd_addr : icache_rd_addr;
            end
            if (grant_i) begin
                starve_cnt <= '0;
            end else if (grant_d && icache_rd_req && !starved) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Beat counter and sticky error flag
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt  <= 2'd0;
            beat_over <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (state != ST_RESP) begin
                beat_cnt  <= 2'd0;
                beat_over <= 1'b0;
            end else if (mem_ret_valid) begin
                beat_cnt <= beat_cnt + 2'd1;
                if ((beat_cnt == exp_idx) && !mem_ret_last) begin
                    beat_over <= 1'b1;
                end
            end
            if (err_early || err_missing || err_stray) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// tb/tb_cache_rd_arbiter.sv - scoreboard testbench for cache_rd_arbiter
module tb_cache_rd_arbiter;
    import cache_rd_arbiter_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        icache_rd_req;
    logic [2:0]  icache_rd_type;
    logic [31:0] icache_rd_addr;
    logic        icache_rd_rdy;
    logic        icache_ret_valid;
    logic        icache_ret_last;
    logic [31:0] icache_ret_data;
    logic        dcache_rd_req;
    logic [2:0]  dcache_rd_type;
    logic [31:0] dcache_rd_addr;
    logic        dcache_rd_rdy;
    logic        dcache_ret_valid;
    logic        dcache_ret_last;
    logic [31:0] dcache_ret_data;
    logic        mem_rd_req;
    logic [2:0]  mem_rd_type;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_rdy;
    logic        mem_ret_valid;
    logic        mem_ret_last;
    logic [31:0] mem_ret_data;
    logic        protocol_err;

    typedef struct {
        logic        own;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    cache_rd_arbiter #(.STARVE_LIMIT(4)) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .icache_rd_req    (icache_rd_req),
        .icache_rd_type   (icache_rd_type),
        .icache_rd_addr   (icache_rd_addr),
        .icache_rd_rdy    (icache_rd_rdy),
        .icache_ret_valid (icache_ret_valid),
        .icache_ret_last  (icache_ret_last),
        .icache_ret_data  (icache_ret_data),
        .dcache_rd_req    (dcache_rd_req),
        .dcache_rd_type   (dcache_rd_type),
        .dcache_rd_addr   (dcache_rd_addr),
        .dcache_rd_rdy    (dcache_rd_rdy),
        .dcache_ret_valid (dcache_ret_valid),
        .dcache_ret_last  (dcache_ret_last),
        .dcache_ret_data  (dcache_ret_data),
        .mem_rd_req       (mem_rd_req),
        .mem_rd_type      (mem_rd_type),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_rdy       (mem_rd_rdy),
        .mem_ret_valid    (mem_ret_valid),
        .mem_ret_last     (mem_ret_last),
        .mem_ret_data     (mem_ret_data),
        .protocol_err     (protocol_err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    // Entered in the cycle after the grant (state REQ). Stalls the bridge for
    // 'stall' cycles, accepts, then returns nbeats beats with last on last_at.
    task automatic serve(input string tag, input logic own, input logic [31:0] addr,
                         input logic [2:0] typ, input int stall, input int nbeats,
                         input int last_at, input logic [31:0] base);
        exp_t e;
        for (int s = 0; s <= stall; s++) begin
            if (s == stall) mem_rd_rdy = 1'b1;
            @(negedge aclk);
            chk({tag, "_req"},  {31'b0, mem_rd_req}, 32'd1);
            chk({tag, "_addr"}, mem_rd_addr, addr);
            chk({tag, "_type"}, {29'b0, mem_rd_type}, {29'b0, typ});
            chk({tag, "_rdy0"}, {30'b0, icache_rd_rdy, dcache_rd_rdy}, 32'd0);
            tick;
        end
        mem_rd_rdy = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            mem_ret_valid = 1'b1;
            mem_ret_last  = (b == last_at);
            mem_ret_data  = base + 32'(b);
            e.own  = own;
            e.data = mem_ret_data;
            e.last = mem_ret_last;
            sb.push_back(e);
            @(negedge aclk);
            chk({tag, "_resp_req0"}, {31'b0, mem_rd_req}, 32'd0);
            tick;
        end
        mem_ret_valid = 1'b0;
        mem_ret_last  = 1'b0;
    endtask

    // Return-side monitor: every forwarded beat must match the scoreboard head
    always @(negedge aclk) begin
        if (icache_ret_valid || dcache_ret_valid) begin
            chk("ret_excl", {31'b0, icache_ret_valid & dcache_ret_valid}, 32'd0);
            chk("sb_has_exp", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("ret_owner", {31'b0, dcache_ret_valid}, {31'b0, mon_e.own});
                chk("ret_data", dcache_ret_valid ? dcache_ret_data : icache_ret_data, mon_e.data);
                chk("ret_last", {31'b0, dcache_ret_valid ? dcache_ret_last : icache_ret_last},
                    {31'b0, mon_e.last});
            end
        end
        if (!icache_ret_valid && icache_ret_last) chk("i_last_wo_valid", {31'b0, icache_ret_last}, 32'd0);
        if (!dcache_ret_valid && dcache_ret_last) chk("d_last_wo_valid", {31'b0, dcache_ret_last}, 32'd0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn        = 1'b0;
        icache_rd_req  = 1'b0;
        icache_rd_type = RD_WORD;
        icache_rd_addr = 32'h0;
        dcache_rd_req  = 1'b0;
        dcache_rd_type = RD_WORD;
        dcache_rd_addr = 32'h0;
        mem_rd_rdy     = 1'b0;
        mem_ret_valid  = 1'b0;
        mem_ret_last   = 1'b0;
        mem_ret_data   = 32'h0;

        repeat (2) @(posedge aclk);
        #1;
        chk("rst_mem_req", {31'b0, mem_rd_req}, 32'd0);
        chk("rst_mem_addr", mem_rd_addr, 32'd0);
        chk("rst_err", {31'b0, protocol_err}, 32'd0);
        chk("rst_ret", {30'b0, icache_ret_valid, dcache_ret_valid}, 32'd0);
        aresetn = 1'b1;
        tick;

        // Simultaneous requests: dcache wins, its address reaches the bridge
        icache_rd_req  = 1'b1;
        icache_rd_type = RD_LINE;
        icache_rd_addr = 32'h1C00_0040;
        dcache_rd_req  = 1'b1;
        dcache_rd_type = RD_WORD;
        dcache_rd_addr = 32'h8000_0010;
        @(negedge aclk);
        chk("t21_d_rdy", {31'b0, dcache_rd_rdy}, 32'd1);
        chk("t21_i_rdy", {31'b0, icache_rd_rdy}, 32'd0);
        tick;
        dcache_rd_req = 1'b0;
        serve("t21", OWN_D, 32'h8000_0010, RD_WORD, 0, 1, 0, 32'h11);

        // Waiting icache line refill, 4 beats 0xA0..0xA3
        @(negedge aclk);
        chk("t22_i_rdy", {31'b0, icache_rd_rdy}, 32'd1);
        tick;
        icache_rd_req = 1'b0;
        serve("t22", OWN_I, 32'h1C00_0040, RD_LINE, 0, 4, 3, 32'hA0);
        chk("t22_sb_empty", sb.size(), 32'd0);

        // Continuous dcache pressure: fifth grant goes to icache
        icache_rd_req  = 1'b1;
        icache_rd_type = RD_WORD;
        icache_rd_addr = 32'h1C00_0100;
        dcache_rd_req  = 1'b1;
        for (int g = 0; g < 5; g++) begin
            logic [31:0] da;
            da = 32'h9000_0000 + 32'(g * 4);
            dcache_rd_addr = da;
            @(negedge aclk);
            chk("t23_grant", {30'b0, icache_rd_rdy, dcache_rd_rdy}, (g == 4) ? 32'd2 : 32'd1);
            tick;
            if (g == 4) begin
                icache_rd_req = 1'b0;
                serve("t23i", OWN_I, 32'h1C00_0100, RD_WORD, 0, 1, 0, 32'hB0 + 32'(g));
            end else begin
                serve("t23d", OWN_D, da, RD_WORD, 0, 1, 0, 32'hB0 + 32'(g));
            end
        end
        chk("t23_starve_clr", 32'(dut.starve_cnt), 32'd0);

        // Bridge stall of 6 cycles with icache also requesting
        icache_rd_req  = 1'b1;
        icache_rd_type = RD_LINE;
        icache_rd_addr = 32'h1C00_0200;
        dcache_rd_addr = 32'h9000_0100;
        @(negedge aclk);
        chk("t24_d_rdy", {31'b0, dcache_rd_rdy}, 32'd1);
        tick;
        dcache_rd_req = 1'b0;
        serve("t24", OWN_D, 32'h9000_0100, RD_WORD, 6, 1, 0, 32'hC0);

        // Line refill with last on beat 1
        @(negedge aclk);
        chk("t25_i_rdy", {31'b0, icache_rd_rdy}, 32'd1);
        chk("t25_err_pre", {31'b0, protocol_err}, 32'd0);
        tick;
        icache_rd_req = 1'b0;
        serve("t25", OWN_I, 32'h1C00_0200, RD_LINE, 0, 2, 1, 32'hD0);
        dcache_rd_req  = 1'b1;
        dcache_rd_addr = 32'h9000_0200;
        @(negedge aclk);
        chk("t25_err", {31'b0, protocol_err}, 32'd1);
        chk("t25_idle", {31'b0, dcache_rd_rdy}, 32'd1);
        tick;
        dcache_rd_req = 1'b0;
        serve("t25b", OWN_D, 32'h9000_0200, RD_WORD, 0, 1, 0, 32'hD8);
        @(negedge aclk);
        chk("t25_sticky", {31'b0, protocol_err}, 32'd1);
        tick;

        // Reset during beat 2 of a line refill
        icache_rd_req  = 1'b1;
        icache_rd_type = RD_LINE;
        icache_rd_addr = 32'h1C00_0300;
        @(negedge aclk);
        chk("t26_i_rdy", {31'b0, icache_rd_rdy}, 32'd1);
        tick;
        icache_rd_req = 1'b0;
        serve("t26", OWN_I, 32'h1C00_0300, RD_LINE, 0, 2, -1, 32'hE0);
        mem_ret_valid = 1'b1;
        mem_ret_last  = 1'b0;
        mem_ret_data  = 32'hE2;
        #1;
        aresetn = 1'b0;
        #1;
        chk("t26_rst_ret", {30'b0, icache_ret_valid, dcache_ret_valid}, 32'd0);
        chk("t26_rst_req", {31'b0, mem_rd_req}, 32'd0);
        chk("t26_rst_err", {31'b0, protocol_err}, 32'd0);
        chk("t26_rst_rdy", {30'b0, icache_rd_rdy, dcache_rd_rdy}, 32'd0);
        mem_ret_valid = 1'b0;
        tick;
        aresetn = 1'b1;
        tick;
        mem_ret_valid = 1'b1;
        mem_ret_last  = 1'b0;
        mem_ret_data  = 32'hE3;
        @(negedge aclk);
        chk("t26_no_fwd", {30'b0, icache_ret_valid, dcache_ret_valid}, 32'd0);
        tick;
        mem_ret_valid = 1'b0;
        @(negedge aclk);
        chk("t26_stray_err", {31'b0, protocol_err}, 32'd1);
        chk("end_sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_rd_arbiter.md
CACHE_RD_ARBITER -- requirements
Module: cache_rd_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive dcache grants while icache_rd_req is pending.
REQ-002 Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- aclk  in  1  clock, all state updates on rising edge
- aresetn  in  1  asynchronous, active-low reset
REQ-003 Icache and dcache ports have identical shape; x = icache | dcache.
- x_rd_req  in  1  refill read request
- x_rd_type  in  3  3'b010 = single word, 3'b100 = 4-word line
- x_rd_addr  in  32  read address
- x_rd_rdy  out  1  request accepted this cycle
- x_ret_valid  out  1  return beat valid
- x_ret_last  out  1  final beat
- x_ret_data  out  32  beat data
REQ-004 Bridge-side port:
- mem_rd_req  out  1
- mem_rd_type  out  3
- mem_rd_addr  out  32
- mem_rd_rdy  in  1
- mem_ret_valid  in  1
- mem_ret_last  in  1
- mem_ret_data  in  32
- protocol_err  out  1  sticky return-protocol violation flag

Function
REQ-005 The block SHALL implement a 3-state FSM: IDLE, REQ, RESP. It SHALL support one outstanding transaction.
REQ-006 IDLE: if any x_rd_req=1, the winner's x_rd_rdy SHALL be 1 combinationally that cycle. owner, type and addr SHALL be latched. Next state REQ. All x_rd_rdy SHALL be 0 outside IDLE.
REQ-007 Arbitration SHALL be dcache over icache, except icache wins when starve_cnt == STARVE_LIMIT.
REQ-008 starve_cnt SHALL increment on a dcache grant while icache_rd_req=1. It SHALL clear on an icache grant. It SHALL saturate at STARVE_LIMIT.
REQ-009 REQ: mem_rd_req=1 with latched type and addr, held stable until mem_rd_rdy=1. Then the next state SHALL be RESP.
- mem_rd_req SHALL be 0 in IDLE and RESP.
- Latency: master accept in cycle N gives mem_rd_req in cycle N+1.
REQ-010 RESP: mem_ret_valid, mem_ret_last and mem_ret_data SHALL pass combinationally (zero latency) to the owner's x_ret_* outputs. The non-owner's x_ret_valid and x_ret_last SHALL be 0.
REQ-011 RESP SHALL move to IDLE on mem_ret_valid & mem_ret_last. A new grant is possible in the following cycle.
REQ-012 A 2-bit beat counter SHALL count mem_ret_valid beats in RESP.
- Expected last beat: index 0 for type 3'b010, index 3 for type 3'b100.
- protocol_err SHALL set if mem_ret_last arrives at any other index.
- protocol_err SHALL set if a beat past the expected index arrives without mem_ret_last.
REQ-013 protocol_err SHALL set if mem_ret_valid=1 in IDLE or REQ. Such beats SHALL NOT be forwarded.
REQ-014 On protocol_err set by early or missing last, the FSM SHALL still follow mem_ret_last for the IDLE transition. No recovery beyond the flag is required.
REQ-015 A master SHALL hold x_rd_req, type and addr until x_rd_rdy. The block SHALL latch only on the accept cycle.
REQ-016 x_ret_data SHALL equal mem_ret_data whenever the corresponding x_ret_valid=1. Otherwise it is don't-care, though driving it to 0 is permitted.

Reset
REQ-017 aresetn low SHALL asynchronously force:
- FSM = IDLE
- starve_cnt, beat counter, latched owner/type/addr = 0
- protocol_err = 0
- mem_rd_req = 0; all x_rd_rdy and x_ret_valid = 0
REQ-018 Reset mid-REQ or mid-RESP SHALL abandon the transaction. Subsequent stray mem_ret_valid in IDLE SHALL set protocol_err.

Structure
REQ-019 Shared package: rd_type encodings (RD_WORD=3'b010, RD_LINE=3'b100), FSM state constants, owner encoding (OWN_I=0, OWN_D=1).
REQ-020 Single flat module; no sub-module is required.

Verification
REQ-021 Both caches request in the same cycle, starve_cnt=0 -> dcache_rd_rdy=1 and icache_rd_rdy=0; mem_rd_addr equals the dcache address one cycle later.
REQ-022 icache line request at 0x1C000040, bridge returns 4 beats 0xA0..0xA3 with last on beat 3 -> icache_ret_valid on 4 cycles, icache_ret_last only on 0xA3, dcache_ret_valid=0 throughout.
REQ-023 dcache requests continuously while icache waits, STARVE_LIMIT=4 -> the 5th grant goes to icache; starve_cnt returns to 0.
REQ-024 mem_rd_rdy held 0 for 6 cycles -> mem_rd_req, mem_rd_addr and mem_rd_type stay stable; x_rd_rdy=0 throughout.
REQ-025 Line request answered with mem_ret_last on beat 1 -> protocol_err=1 and sticky; FSM=IDLE next cycle.
REQ-026 aresetn pulsed low during RESP beat 2 -> all outputs 0 immediately; next mem_ret_valid sets protocol_err.
